// File: rtl/vc_xbar_pkg.sv
// Shared constants for the crossbar bank arbiter: default sizes and perf counter width.
package vc_xbar_pkg;
  localparam int XBAR_M         = 8;
  localparam int XBAR_N         = 16;
  localparam int XBAR_PLD_WIDTH = 32;
  localparam int XBAR_CNT_W     = 32;
endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arb #(
  parameter int M = 8
) (
  input  logic [M-1:0]         req,
  input  logic [$clog2(M)-1:0] ptr,
  output logic [M-1:0]         gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < M; off++) begin
      idx = int'(ptr) + off;
      if (idx >= M) idx = idx - M;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_bank_arbiter.sv
// M-requester to N-bank crossbar with per-bank round-robin arbitration and one-deep output slots.
// Optional perf counters are enabled with the XBAR_ARB_PERF_CNT_EN macro.
module xbar_bank_arbiter
  import vc_xbar_pkg::*;
#(
  parameter int M         = XBAR_M,
  parameter int N         = XBAR_N,
  parameter int PLD_WIDTH = XBAR_PLD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M-1:0]           in_vld,
  input  logic [PLD_WIDTH-1:0]   in_pld [M],
  input  logic [$clog2(N)-1:0]   in_dst [M],
  output logic [M-1:0]           in_rdy,
  output logic [N-1:0]           out_vld,
  output logic [PLD_WIDTH-1:0]   out_pld [N],
  output logic [$clog2(M)-1:0]   out_src [N],
  input  logic [N-1:0]           out_rdy
`ifdef XBAR_ARB_PERF_CNT_EN
  ,
  output logic [XBAR_CNT_W-1:0]  perf_conflict_cnt,
  output logic [XBAR_CNT_W-1:0]  perf_grant_cnt
`endif
);

  localparam int SW = $clog2(M);

  logic [SW-1:0]        ptr_q     [N];
  logic [SW-1:0]        ptr_d     [N];
  logic [N-1:0]         out_vld_q, out_vld_d;
  logic [PLD_WIDTH-1:0] out_pld_q [N];
  logic [PLD_WIDTH-1:0] out_pld_d [N];
  logic [SW-1:0]        out_src_q [N];
  logic [SW-1:0]        out_src_d [N];
  logic [M-1:0]         req       [N];
  logic [M-1:0]         gnt       [N];
  logic [N-1:0]         bank_free;
  logic [M-1:0]         in_rdy_c;

  // Out-of-range destinations match no bank, so they are never requested.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      req[j] = '0;
      for (int i = 0; i < M; i++)
        if (in_vld[i] && int'(in_dst[i]) == j) req[j][i] = 1'b1;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_arb
    rr_arb #(.M(M)) u_rr_arb (
      .req (req[j]),
      .ptr (ptr_q[j]),
      .gnt (gnt[j])
    );
  end

  always_comb begin
    in_rdy_c = '0;
    for (int j = 0; j < N; j++) begin
      bank_free[j] = !out_vld_q[j] || out_rdy[j];
      ptr_d[j]     = ptr_q[j];
      out_vld_d[j] = out_vld_q[j] && !out_rdy[j];
      out_pld_d[j] = out_pld_q[j];
      out_src_d[j] = out_src_q[j];
      if (bank_free[j]) begin
        for (int i = 0; i < M; i++) begin
          if (gnt[j][i]) begin
            in_rdy_c[i]  = 1'b1;
            out_vld_d[j] = 1'b1;
            out_pld_d[j] = in_pld[i];
            out_src_d[j] = SW'(i);
            ptr_d[j]     = (i == M - 1) ? '0 : SW'(i + 1);
          end
        end
      end
    end
    if (rst) in_rdy_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= '0;
      for (int j = 0; j < N; j++) begin
        ptr_q[j]     <= '0;
        out_pld_q[j] <= '0;
        out_src_q[j] <= '0;
      end
    end else begin
      out_vld_q <= out_vld_d;
      for (int j = 0; j < N; j++) begin
        ptr_q[j]     <= ptr_d[j];
        out_pld_q[j] <= out_pld_d[j];
        out_src_q[j] <= out_src_d[j];
      end
    end
  end

  assign in_rdy  = in_rdy_c;
  assign out_vld = out_vld_q;
  assign out_pld = out_pld_q;
  assign out_src = out_src_q;

  always @(posedge clk) begin
    for (int i = 0; i < M; i++)
      if (!rst && in_vld[i]) assert (int'(in_dst[i]) < N);
  end

`ifdef XBAR_ARB_PERF_CNT_EN
  logic [XBAR_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [XBAR_CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  function automatic logic [XBAR_CNT_W-1:0] sat_add(input logic [XBAR_CNT_W-1:0] a,
                                                    input logic [XBAR_CNT_W-1:0] b);
    logic [XBAR_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[XBAR_CNT_W] ? '1 : sum[XBAR_CNT_W-1:0];
  endfunction

  always_comb begin
    logic [XBAR_CNT_W-1:0] n_xfer;
    n_xfer = '0;
    for (int i = 0; i < M; i++)
      if (in_vld[i] && in_rdy_c[i]) n_xfer = n_xfer + 1'b1;
    grant_cnt_d    = sat_add(grant_cnt_q, n_xfer);
    conflict_cnt_d = sat_add(conflict_cnt_q, {{(XBAR_CNT_W-1){1'b0}}, |(in_vld & ~in_rdy_c)});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      grant_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      grant_cnt_q    <= grant_cnt_d;
    end
  end

  assign perf_conflict_cnt = conflict_cnt_q;
  assign perf_grant_cnt    = grant_cnt_q;
`endif

endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// Directed self-checking bench for xbar_bank_arbiter (M=8, N=16, PLD_WIDTH=32).
module tb_xbar_bank_arbiter;

  localparam int M = 8;
  localparam int N = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  in_vld;
  logic [PW-1:0] in_pld [M];
  logic [3:0]    in_dst [M];
  logic [M-1:0]  in_rdy;
  logic [N-1:0]  out_vld;
  logic [PW-1:0] out_pld [N];
  logic [2:0]    out_src [N];
  logic [N-1:0]  out_rdy;
`ifdef XBAR_ARB_PERF_CNT_EN
  logic [31:0]   perf_conflict_cnt;
  logic [31:0]   perf_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  xbar_bank_arbiter #(.M(M), .N(N), .PLD_WIDTH(PW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_pld  (in_pld),
    .in_dst  (in_dst),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_pld (out_pld),
    .out_src (out_src),
    .out_rdy (out_rdy)
`ifdef XBAR_ARB_PERF_CNT_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_grant_cnt    (perf_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_vld = '0;
    for (int i = 0; i < M; i++) begin
      in_pld[i] = '0;
      in_dst[i] = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    out_rdy = '1;
    tick();
    tick();
    in_vld = 8'hFF;
    #1;
    checks++;
    if (in_rdy !== 8'h00) begin errors++; $display("FAIL reset_in_rdy got %h exp %h", in_rdy, 8'h00); end
    checks++;
    if (out_vld !== 16'h0000) begin errors++; $display("FAIL reset_out_vld got %h exp %h", out_vld, 16'h0000); end
    checks++;
    if (out_pld[3] !== 32'h0) begin errors++; $display("FAIL reset_out_pld got %h exp %h", out_pld[3], 32'h0); end
    checks++;
    if (out_src[3] !== 3'd0) begin errors++; $display("FAIL reset_out_src got %0d exp %0d", out_src[3], 0); end
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_vld    = 8'h01;
    in_dst[0] = 4'd3;
    in_pld[0] = 32'hA5;
    out_rdy   = '1;
    #1;
    checks++;
    if (in_rdy !== 8'h01) begin errors++; $display("FAIL single_in_rdy got %h exp %h", in_rdy, 8'h01); end
    tick();
    idle();
    checks++;
    if (out_vld !== 16'h0008) begin errors++; $display("FAIL single_out_vld got %h exp %h", out_vld, 16'h0008); end
    checks++;
    if (out_pld[3] !== 32'hA5) begin errors++; $display("FAIL single_out_pld got %h exp %h", out_pld[3], 32'hA5); end
    checks++;
    if (out_src[3] !== 3'd0) begin errors++; $display("FAIL single_out_src got %0d exp %0d", out_src[3], 0); end
    tick();
    checks++;
    if (out_vld !== 16'h0000) begin errors++; $display("FAIL drain_out_vld got %h exp %h", out_vld, 16'h0000); end
    checks++;
    if (out_pld[3] !== 32'hA5) begin errors++; $display("FAIL drain_pld_hold got %h exp %h", out_pld[3], 32'hA5); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rdy [4];
    logic [2:0] exp_src [4];
    exp_rdy[0] = 8'h01; exp_rdy[1] = 8'h02; exp_rdy[2] = 8'h04; exp_rdy[3] = 8'h01;
    exp_src[0] = 3'd0;  exp_src[1] = 3'd1;  exp_src[2] = 3'd2;  exp_src[3] = 3'd0;
    in_vld = 8'h07;
    for (int i = 0; i < 3; i++) begin
      in_dst[i] = 4'd5;
      in_pld[i] = 32'h100 + i;
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_rdy !== exp_rdy[k]) begin errors++; $display("FAIL rr_in_rdy[%0d] got %h exp %h", k, in_rdy, exp_rdy[k]); end
      tick();
      checks++;
      if (out_vld[5] !== 1'b1) begin errors++; $display("FAIL rr_out_vld[%0d] got %b exp 1", k, out_vld[5]); end
      checks++;
      if (out_src[5] !== exp_src[k]) begin errors++; $display("FAIL rr_out_src[%0d] got %0d exp %0d", k, out_src[5], exp_src[k]); end
      checks++;
      if (out_pld[5] !== 32'h100 + exp_src[k]) begin errors++; $display("FAIL rr_out_pld[%0d] got %h exp %h", k, out_pld[5], 32'h100 + exp_src[k]); end
    end
    idle();
    tick();
  endtask

  task automatic test_stall();
    in_vld    = 8'h10;
    in_dst[4] = 4'd7;
    in_pld[4] = 32'h77;
    tick();
    out_rdy[7] = 1'b0;
    in_pld[4]  = 32'h99;
    checks++;
    if (out_pld[7] !== 32'h77) begin errors++; $display("FAIL stall_fill_pld got %h exp %h", out_pld[7], 32'h77); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_rdy[4] !== 1'b0) begin errors++; $display("FAIL stall_in_rdy[%0d] got %b exp 0", k, in_rdy[4]); end
      tick();
      checks++;
      if (out_vld[7] !== 1'b1 || out_pld[7] !== 32'h77) begin
        errors++; $display("FAIL stall_hold[%0d] got vld %b pld %h exp vld 1 pld %h", k, out_vld[7], out_pld[7], 32'h77);
      end
    end
    out_rdy[7] = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 8'h10) begin errors++; $display("FAIL stall_release_rdy got %h exp %h", in_rdy, 8'h10); end
    tick();
    idle();
    checks++;
    if (out_pld[7] !== 32'h99 || out_src[7] !== 3'd4) begin
      errors++; $display("FAIL stall_refill got pld %h src %0d exp pld %h src 4", out_pld[7], out_src[7], 32'h99);
    end
    tick();
  endtask

  task automatic test_all_distinct();
    in_vld = 8'hFF;
    for (int i = 0; i < M; i++) begin
      in_dst[i] = 4'(i);
      in_pld[i] = 32'h200 + i;
    end
    #1;
    checks++;
    if (in_rdy !== 8'hFF) begin errors++; $display("FAIL distinct_in_rdy got %h exp %h", in_rdy, 8'hFF); end
    tick();
    idle();
    checks++;
    if (out_vld !== 16'h00FF) begin errors++; $display("FAIL distinct_out_vld got %h exp %h", out_vld, 16'h00FF); end
    checks++;
    if (out_pld[6] !== 32'h206 || out_src[6] !== 3'd6) begin
      errors++; $display("FAIL distinct_bank6 got pld %h src %0d exp pld %h src 6", out_pld[6], out_src[6], 32'h206);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    in_vld    = 8'h03;
    in_dst[0] = 4'd0;
    in_dst[1] = 4'd1;
    in_pld[0] = 32'hC0;
    in_pld[1] = 32'hC1;
    tick();
    out_rdy = '0;
    checks++;
    if (out_vld !== 16'h0003) begin errors++; $display("FAIL midflight_fill got %h exp %h", out_vld, 16'h0003); end
    in_dst[1] = 4'd0;
    #1;
    checks++;
    if (in_rdy !== 8'h00) begin errors++; $display("FAIL midflight_stall got %h exp %h", in_rdy, 8'h00); end
    rst = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 8'h00) begin errors++; $display("FAIL midflight_rst_rdy got %h exp %h", in_rdy, 8'h00); end
    tick();
    checks++;
    if (out_vld !== 16'h0000) begin errors++; $display("FAIL midflight_rst_vld got %h exp %h", out_vld, 16'h0000); end
    rst     = 1'b0;
    out_rdy = '1;
    #1;
    checks++;
    if (in_rdy !== 8'h01) begin errors++; $display("FAIL post_reset_rdy got %h exp %h", in_rdy, 8'h01); end
    tick();
    idle();
    checks++;
    if (out_vld !== 16'h0001 || out_src[0] !== 3'd0) begin
      errors++; $display("FAIL post_reset_out got vld %h src %0d exp vld 0001 src 0", out_vld, out_src[0]);
    end
    tick();
  endtask

`ifdef XBAR_ARB_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    checks++;
    if (perf_grant_cnt !== 32'd0 || perf_conflict_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset got grant %0d conflict %0d exp 0 0", perf_grant_cnt, perf_conflict_cnt);
    end
    out_rdy   = '1;
    in_vld    = 8'h03;
    in_dst[0] = 4'd1;
    in_dst[1] = 4'd1;
    tick();
    tick();
    tick();
    idle();
    checks++;
    if (perf_grant_cnt !== 32'd3) begin errors++; $display("FAIL perf_grant got %0d exp 3", perf_grant_cnt); end
    checks++;
    if (perf_conflict_cnt !== 32'd3) begin errors++; $display("FAIL perf_conflict got %0d exp 3", perf_conflict_cnt); end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_all_distinct();
    test_reset_midflight();
`ifdef XBAR_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
